i2s_rx_capture: RTL and testbench

//  I2S receiver for the codec record path: the counterpart of the I2S playback transmitter.

---
 rtl/audio_pkg.sv | 25 ++
 rtl/i2s_rx_capture_if.sv | 32 +++
 rtl/i2s_rx_capture_sync.sv | 43 ++++
 rtl/i2s_rx_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_i2s_rx_capture.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio-path definitions for the codec record/playback blocks.
//   AUDIO_SAMPLE_BITS : default captured bits per channel
//   stereo_sample_t   : one {left, right} signed sample pair
//   i2s_rx_state_t    : I2S receiver frame-tracking states
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int AUDIO_SAMPLE_BITS = 16;

   typedef struct packed {
      logic [AUDIO_SAMPLE_BITS-1:0] l;
      logic [AUDIO_SAMPLE_BITS-1:0] r;
   } stereo_sample_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_DELAY = 3'd2,
      ST_SHIFT = 3'd3,
      ST_PAD   = 3'd4
   } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_capture_if.sv
// -----------------------------------------------------------------------------
// i2s_rx_capture_if
// Sample-pair output bus of the I2S receiver.
//   sample_l / sample_r : held signed pair
//   sample_valid        : held pair is valid
//   sample_ready        : consumer accepts on valid && ready at a clock edge
//   overflow            : 1-cycle pulse, unconsumed pair overwritten
//   frame_err           : 1-cycle pulse, slot shorter than the sample width
// Modports: master (receiver side), slave (consumer side).
// -----------------------------------------------------------------------------
interface i2s_rx_capture_if #(
   parameter int SAMPLE_BITS = audio_pkg::AUDIO_SAMPLE_BITS
) ();

   logic [SAMPLE_BITS-1:0] sample_l;
   logic [SAMPLE_BITS-1:0] sample_r;
   logic                   sample_valid;
   logic                   sample_ready;
   logic                   overflow;
   logic                   frame_err;

   modport master (
      output sample_l, sample_r, sample_valid, overflow, frame_err,
      input  sample_ready
   );

   modport slave (
      input  sample_l, sample_r, sample_valid, overflow, frame_err,
      output sample_ready
   );

endinterface

// File: rtl/i2s_rx_capture_sync.sv
// -----------------------------------------------------------------------------
// i2s_pin_sync
// Multi-flop synchronizer for one asynchronous pin, plus registered rise/fall
// pulses derived from the last sync stage against one extra delay flop.
//   clk  : sampling clock          rstn : async active-low reset
//   din  : raw pin                 dout : synchronized level
//   rise : 1-cycle pulse on 0->1   fall : 1-cycle pulse on 1->0
// -----------------------------------------------------------------------------
module i2s_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_reg;
   logic              dly_reg;
   logic              rise_reg;
   logic              fall_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_reg <= '0;
         dly_reg  <= 1'b0;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], din};
         dly_reg  <= sync_reg[STAGES-1];
         rise_reg <= sync_reg[STAGES-1] & ~dly_reg;
         fall_reg <= ~sync_reg[STAGES-1] & dly_reg;
      end
   end

   assign dout = sync_reg[STAGES-1];
   assign rise = rise_reg;
   assign fall = fall_reg;

endmodule

// File: rtl/i2s_rx_capture.sv
// -----------------------------------------------------------------------------
// i2s_rx_capture
// I2S receiver for the codec record path. Observes bclk/lrc (driven by the
// playback transmitter) and recdat, all in the mclk domain, and presents one
// signed stereo pair per frame on a valid/ready bus.
//   mclk, rstn          : sole clock (>= 4x bclk), async active-low reset
//   en                  : capture enable, low forces IDLE
//   i2s_bclk/lrc/recdat : observed I2S pins (lrc 0 = left, 1 = right)
//   cap                 : sample bus (i2s_rx_capture_if.master)
// Optional build macro I2S_RX_PEAK_EN adds peak_clr (in) and peak_l/peak_r
// (out): running maximum magnitude of committed samples.
// -----------------------------------------------------------------------------
module i2s_rx_capture
   import audio_pkg::*;
#(
   parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS,
   parameter int SLOT_BITS   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   mclk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   i2s_bclk,
   input  logic                   i2s_lrc,
   input  logic                   i2s_recdat,
`ifdef I2S_RX_PEAK_EN
   input  logic                   peak_clr,
   output logic [SAMPLE_BITS-1:0] peak_l,
   output logic [SAMPLE_BITS-1:0] peak_r,
`endif
   i2s_rx_capture_if.master       cap
);

   // Counter is sized for a full slot so it can never wrap inside one.
   localparam int                CNT_W = $clog2(SLOT_BITS + 1);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SAMPLE_BITS - 1);

   logic bclk_rise, bclk_fall_unused, bclk_level_unused;
   logic lrc_rise, lrc_fall, lrc_level_unused;
   logic recdat_s, recdat_rise_unused, recdat_fall_unused;
   logic lrc_edge;

   i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
      .clk(mclk), .rstn(rstn), .din(i2s_bclk),
      .dout(bclk_level_unused), .rise(bclk_rise), .fall(bclk_fall_unused));

   i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_lrc_sync (
      .clk(mclk), .rstn(rstn), .din(i2s_lrc),
      .dout(lrc_level_unused), .rise(lrc_rise), .fall(lrc_fall));

   // recdat passes one stage less than the registered bclk pulse, so the level
   // seen alongside bclk_rise is the pin value from mid high-phase of bclk.
   i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_recdat_sync (
      .clk(mclk), .rstn(rstn), .din(i2s_recdat),
      .dout(recdat_s), .rise(recdat_rise_unused), .fall(recdat_fall_unused));

   assign lrc_edge = lrc_rise | lrc_fall;

   i2s_rx_state_t          state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   chan_reg, chan_next;          // 0 = left slot
   logic                   have_left_reg, have_left_next;
   logic [SAMPLE_BITS-2:0] shift_reg, shift_next;
   logic [SAMPLE_BITS-1:0] left_reg, left_next;
   logic [SAMPLE_BITS-1:0] shifted;
   logic                   commit;
   logic                   short_slot;

   logic [SAMPLE_BITS-1:0] hold_l_reg, hold_r_reg;
   logic                   valid_reg, ovf_reg, ferr_reg;
   logic                   accept;

   // Word including the bit arriving on this bclk rise.
   assign shifted = {shift_reg, recdat_s};
   assign accept  = valid_reg & cap.sample_ready;

   always_ff @(posedge mclk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         chan_reg      <= 1'b0;
         have_left_reg <= 1'b0;
         shift_reg     <= '0;
         left_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         chan_reg      <= chan_next;
         have_left_reg <= have_left_next;
         shift_reg     <= shift_next;
         left_reg      <= left_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      chan_next      = chan_reg;
      have_left_next = have_left_reg;
      shift_next     = shift_reg;
      left_next      = left_reg;
      commit         = 1'b0;
      short_slot     = 1'b0;
      if (!en) begin
         state_next     = ST_IDLE;
         have_left_next = 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE: state_next = ST_ALIGN;
            ST_ALIGN: begin
               // Always start on the left slot so a pair is never split.
               if (lrc_fall) begin
                  state_next     = ST_DELAY;
                  chan_next      = 1'b0;
                  have_left_next = 1'b0;
               end
            end
            ST_DELAY: begin
               // First rise after the lrc edge still carries the previous LSB.
               if (bclk_rise) begin
                  state_next = ST_SHIFT;
                  cnt_next   = '0;
               end
            end
            ST_SHIFT: begin
               if (lrc_edge) begin
                  short_slot     = 1'b1;
                  state_next     = ST_ALIGN;
                  have_left_next = 1'b0;
               end else if (bclk_rise) begin
                  shift_next = shifted[SAMPLE_BITS-2:0];
                  if (cnt_reg == LAST) begin
                     state_next = ST_PAD;
                     if (!chan_reg) begin
                        left_next      = shifted;
                        have_left_next = 1'b1;
                     end else begin
                        commit         = have_left_reg;
                        have_left_next = 1'b0;
                     end
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end
            ST_PAD: begin
               if (lrc_edge) begin
                  state_next = ST_DELAY;
                  chan_next  = ~chan_reg;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Output hold register: newest pair wins; a same-cycle accept consumes the
   // old pair, so overwrite only counts as overflow when nobody took it.
   always_ff @(posedge mclk or negedge rstn) begin
      if (!rstn) begin
         hold_l_reg <= '0;
         hold_r_reg <= '0;
         valid_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
         ferr_reg   <= 1'b0;
      end else begin
         ferr_reg <= short_slot;
         if (commit) begin
            hold_l_reg <= left_reg;
            hold_r_reg <= shifted;
            valid_reg  <= 1'b1;
            ovf_reg    <= valid_reg & ~cap.sample_ready;
         end else begin
            ovf_reg <= 1'b0;
            if (accept) valid_reg <= 1'b0;
         end
      end
   end

   assign cap.sample_l     = hold_l_reg;
   assign cap.sample_r     = hold_r_reg;
   assign cap.sample_valid = valid_reg;
   assign cap.overflow     = ovf_reg;
   assign cap.frame_err    = ferr_reg;

`ifdef I2S_RX_PEAK_EN
   // Magnitude of a two's complement sample; the most negative value
   // saturates to the largest positive one.
   function automatic logic [SAMPLE_BITS-1:0] mag(input logic [SAMPLE_BITS-1:0] x);
      if (!x[SAMPLE_BITS-1])
         return x;
      else if (x == {1'b1, {(SAMPLE_BITS-1){1'b0}}})
         return {1'b0, {(SAMPLE_BITS-1){1'b1}}};
      else
         return ~x + 1'b1;
   endfunction

   logic [SAMPLE_BITS-1:0] peak_l_reg, peak_r_reg;
   logic [SAMPLE_BITS-1:0] mag_l, mag_r, base_l, base_r;

   assign mag_l  = mag(left_reg);
   assign mag_r  = mag(shifted);
   assign base_l = peak_clr ? '0 : peak_l_reg;
   assign base_r = peak_clr ? '0 : peak_r_reg;

   always_ff @(posedge mclk or negedge rstn) begin
      if (!rstn) begin
         peak_l_reg <= '0;
         peak_r_reg <= '0;
      end else if (commit) begin
         peak_l_reg <= (mag_l > base_l) ? mag_l : base_l;
         peak_r_reg <= (mag_r > base_r) ? mag_r : base_r;
      end else if (peak_clr) begin
         peak_l_reg <= '0;
         peak_r_reg <= '0;
      end
   end

   assign peak_l = peak_l_reg;
   assign peak_r = peak_r_reg;
`endif

endmodule

// File: tb/tb_i2s_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_capture
// Directed bench: an I2S BFM (bclk = mclk/8, 32 bclk per slot) drives frames;
// a negedge monitor tallies valid rises, pulses and accepted pairs.
// Define I2S_RX_PEAK_EN to also exercise the peak outputs.
// -----------------------------------------------------------------------------
module tb_i2s_rx_capture;
   import audio_pkg::*;

   logic mclk = 1'b0;
   logic rstn, en, i2s_bclk, i2s_lrc, i2s_recdat;
`ifdef I2S_RX_PEAK_EN
   logic        peak_clr;
   logic [15:0] peak_l, peak_r;
`endif

   i2s_rx_capture_if #(.SAMPLE_BITS(16)) cap_if ();

   i2s_rx_capture #(.SAMPLE_BITS(16), .SLOT_BITS(32), .SYNC_STAGES(2)) dut (
      .mclk       (mclk),
      .rstn       (rstn),
      .en         (en),
      .i2s_bclk   (i2s_bclk),
      .i2s_lrc    (i2s_lrc),
      .i2s_recdat (i2s_recdat),
`ifdef I2S_RX_PEAK_EN
      .peak_clr   (peak_clr),
      .peak_l     (peak_l),
      .peak_r     (peak_r),
`endif
      .cap        (cap_if)
   );

   always #5 mclk = ~mclk;

   int             n_vec = 0;
   int             n_miss = 0;
   int             n_rise, n_valid_cyc, n_ovf, n_ferr;
   time            rise_t, last_r_t;
   logic           valid_d = 1'b0;
   stereo_sample_t acc_q[$];
   event           last_r_ev;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic clear_stats();
      n_rise = 0; n_valid_cyc = 0; n_ovf = 0; n_ferr = 0;
      acc_q.delete();
   endtask

   // Monitor on the falling edge, away from the DUT's active edge.
   always @(negedge mclk) begin
      stereo_sample_t s;
      if (cap_if.sample_valid && !valid_d) begin
         n_rise++;
         rise_t = $time - 5;
      end
      valid_d = cap_if.sample_valid;
      if (cap_if.sample_valid) n_valid_cyc++;
      if (cap_if.overflow)     n_ovf++;
      if (cap_if.frame_err)    n_ferr++;
      if (cap_if.sample_valid && cap_if.sample_ready) begin
         s.l = cap_if.sample_l;
         s.r = cap_if.sample_r;
         acc_q.push_back(s);
      end
   end

   // One slot: lrc and data change on bclk fall; MSB on the 2nd rise.
   task automatic drive_slot(input logic lrc_val, input logic [15:0] w, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         i2s_bclk   = 1'b0;
         i2s_lrc    = lrc_val;
         i2s_recdat = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
         #40;
         i2s_bclk = 1'b1;
         if (lrc_val && k == 16) begin
            last_r_t = $time;
            -> last_r_ev;
         end
         #40;
      end
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
      drive_slot(1'b0, l, 32);
      drive_slot(1'b1, r, 32);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; en = 1'b0; cap_if.sample_ready = 1'b0;
      i2s_bclk = 1'b1; i2s_lrc = 1'b1; i2s_recdat = 1'b0;
`ifdef I2S_RX_PEAK_EN
      peak_clr = 1'b0;
`endif
      clear_stats();
      // Pin changes land 2 ns after a negedge, 3 ns before a posedge.
      #102;
      check_val("rst_valid", 32'(cap_if.sample_valid), 32'h0);
      check_val("rst_l", 32'(cap_if.sample_l), 32'h0);
      check_val("rst_r", 32'(cap_if.sample_r), 32'h0);
      check_val("rst_ovf", 32'(cap_if.overflow), 32'h0);
      check_val("rst_ferr", 32'(cap_if.frame_err), 32'h0);
      rstn = 1'b1;
      #40;

      // 1: single frame, ready high
      en = 1'b1; cap_if.sample_ready = 1'b1;
      drive_slot(1'b1, 16'h0000, 4);
      send_frame(16'h8001, 16'h7FFE);
      check_val("t1_rises", 32'(n_rise), 32'd1);
      check_val("t1_acc_n", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) begin
         check_val("t1_l", 32'(acc_q[0].l), 32'h8001);
         check_val("t1_r", 32'(acc_q[0].r), 32'h7FFE);
      end
      check_val("t1_valid_cyc", 32'(n_valid_cyc), 32'd1);
      // Pin rise at T; posedges at T+3 (sync0), T+13 (sync1), T+23 (edge
      // detect), T+33 (commit) -> valid rises on the 4th edge.
      check_val("t1_latency_ns", 32'(rise_t - last_r_t), 32'd33);

      // 2: ready low for 3 frames
      cap_if.sample_ready = 1'b0;
      clear_stats();
      send_frame(16'h1111, 16'h2222);
      send_frame(16'h3333, 16'h4444);
      send_frame(16'h5555, 16'h6666);
      check_val("t2_ovf", 32'(n_ovf), 32'd2);
      check_val("t2_rises", 32'(n_rise), 32'd1);
      check_val("t2_valid", 32'(cap_if.sample_valid), 32'h1);
      check_val("t2_l", 32'(cap_if.sample_l), 32'h5555);
      check_val("t2_r", 32'(cap_if.sample_r), 32'h6666);

      // 3: ready coincides with the commit edge
      clear_stats();
      fork
         send_frame(16'hC0DE, 16'hBEEF);
         begin
            @(last_r_ev);
            #31 cap_if.sample_ready = 1'b1;   // high across the T+33 edge only
            #5  cap_if.sample_ready = 1'b0;
            #2;
            check_val("t3_valid", 32'(cap_if.sample_valid), 32'h1);
            check_val("t3_l", 32'(cap_if.sample_l), 32'hC0DE);
            check_val("t3_r", 32'(cap_if.sample_r), 32'hBEEF);
            check_val("t3_ovf_now", 32'(cap_if.overflow), 32'h0);
         end
      join
      check_val("t3_ovf", 32'(n_ovf), 32'd0);
      cap_if.sample_ready = 1'b1;
      #20 cap_if.sample_ready = 1'b0;
      #8;
      check_val("t3_consumed", 32'(cap_if.sample_valid), 32'h0);
      #2;

      // 4: short right slot, one frame to realign, then a good frame
      cap_if.sample_ready = 1'b1;
      clear_stats();
      drive_slot(1'b0, 16'h1111, 32);
      drive_slot(1'b1, 16'h2222, 10);
      send_frame(16'h5A5A, 16'hA5A5);
      send_frame(16'h1234, 16'hABCD);
      check_val("t4_ferr", 32'(n_ferr), 32'd1);
      check_val("t4_rises", 32'(n_rise), 32'd1);
      check_val("t4_acc_n", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) begin
         check_val("t4_l", 32'(acc_q[0].l), 32'h1234);
         check_val("t4_r", 32'(acc_q[0].r), 32'hABCD);
      end

      // 5a: en dropped mid-left, restored mid-right: no commit
      clear_stats();
      fork
         send_frame(16'h1357, 16'h2468);
         begin
            #800  en = 1'b0;
            #2560 en = 1'b1;
         end
      join
      check_val("t5a_rises", 32'(n_rise), 32'd0);

      // 5b: en dropped mid-left, then reset mid-right
      fork
         send_frame(16'h1357, 16'h2468);
         begin
            #800  en = 1'b0;
            #2560 rstn = 1'b0;
            #98;
            check_val("t5_valid", 32'(cap_if.sample_valid), 32'h0);
            check_val("t5_l", 32'(cap_if.sample_l), 32'h0);
            check_val("t5_r", 32'(cap_if.sample_r), 32'h0);
            #2 rstn = 1'b1; en = 1'b1;
         end
      join
      check_val("t5_rises", 32'(n_rise), 32'd0);
      check_val("t5_pulses", 32'(n_ovf + n_ferr), 32'd0);
      send_frame(16'h0F0F, 16'hF0F0);
      check_val("t5_rec_rises", 32'(n_rise), 32'd1);
      if (acc_q.size() > 0) begin
         check_val("t5_rec_l", 32'(acc_q[0].l), 32'h0F0F);
         check_val("t5_rec_r", 32'(acc_q[0].r), 32'hF0F0);
      end else begin
         check_val("t5_rec_acc_n", 32'(acc_q.size()), 32'd1);
      end

`ifdef I2S_RX_PEAK_EN
      // 6: peak tracking
      peak_clr = 1'b1;
      #10 peak_clr = 1'b0;
      send_frame(16'hFED4, 16'h8000);   // L=-300, R=-32768
      send_frame(16'h00C8, 16'h0064);   // L=200,  R=100
      check_val("t6_peak_l", 32'(peak_l), 32'h012C);
      check_val("t6_peak_r", 32'(peak_r), 32'h7FFF);
      peak_clr = 1'b1;
      #10 peak_clr = 1'b0;
      #8;
      check_val("t6_clr_l", 32'(peak_l), 32'h0);
      check_val("t6_clr_r", 32'(peak_r), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
